// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module   : ram_arbiter
//  Brief    : Two-port sequencer for the 256x4 nibble RAM. Each grant runs
//             SETUP -> XFER -> DONE and drives address, write enable and the
//             shared tristate data bus. ARB_ROUND_ROBIN_EN selects
//             round-robin arbitration; otherwise port 0 has fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter (
    input  logic       clk,
    input  logic       reset,

    input  logic       p0_req,
    input  logic       p0_we,
    input  logic [7:0] p0_addr,
    input  logic [3:0] p0_wdata,
    output logic       p0_ack,
    output logic [3:0] p0_rdata,

    input  logic       p1_req,
    input  logic       p1_we,
    input  logic [7:0] p1_addr,
    input  logic [3:0] p1_wdata,
    output logic       p1_ack,
    output logic [3:0] p1_rdata,

    output logic [7:0] ram_address,
    output logic       ram_write_enable,
    inout  wire  [3:0] ram_data_bus,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;

    logic       grant_valid;
    logic       grant_sel;

    logic       lat_we;
    logic [7:0] lat_addr;
    logic [3:0] lat_wdata;
    logic       lat_grant;

    logic [3:0] rd_capture;
    logic       bus_drive;

    assign grant_valid = p0_req | p1_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Index of the most recently granted port; reset value 1 favours port 0.
    logic rr_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (state == IDLE && grant_valid) begin
            rr_last <= grant_sel;
        end
    end

    always_comb begin
        grant_sel = p1_req;
        if (p0_req && p1_req) begin
            grant_sel = ~rr_last;
        end
    end
`else
    always_comb begin
        grant_sel = ~p0_req;
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = SETUP;
            SETUP:   next_state = XFER;
            XFER:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 4'h0;
            lat_grant <= 1'b0;
            p0_rdata  <= 4'h0;
            p1_rdata  <= 4'h0;
        end else begin
            state <= next_state;
            if (state == IDLE && grant_valid) begin
                lat_grant <= grant_sel;
                lat_we    <= grant_sel ? p1_we    : p0_we;
                lat_addr  <= grant_sel ? p1_addr  : p0_addr;
                lat_wdata <= grant_sel ? p1_wdata : p0_wdata;
            end
            // rd_capture was loaded on the falling edge inside XFER.
            if (state == XFER && !lat_we) begin
                if (lat_grant) begin
                    p1_rdata <= rd_capture;
                end else begin
                    p0_rdata <= rd_capture;
                end
            end
        end
    end

    // The RAM drives the bus only while clk is high, so sample mid-cycle.
    always_ff @(negedge clk) begin
        if (state == XFER) begin
            rd_capture <= ram_data_bus;
        end
    end

    assign bus_drive        = (state == SETUP) && lat_we;
    assign ram_write_enable = bus_drive;
    assign ram_data_bus     = bus_drive ? lat_wdata : 4'bzzzz;
    assign ram_address      = lat_addr;
    assign busy             = (state != IDLE);
    assign p0_ack           = (state == DONE) && !lat_grant;
    assign p1_ack           = (state == DONE) &&  lat_grant;

endmodule

`default_nettype wire
